// File: rtl/relay_pkg.sv
// relay_pkg: opcodes, register map and FSM states shared by the relay register bank
package relay_pkg;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LD8   = 3'd1,
    OP_SEL8  = 3'd2,
    OP_LD16  = 3'd3,
    OP_SEL16 = 3'd4,
    OP_INC16 = 3'd5,
    OP_CLR8  = 3'd6,
    OP_ILL   = 3'd7
  } opT;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } stateT;
  localparam int REG_A = 0;
  localparam int REG_B = 1;
  localparam int REG_C = 2;
  localparam int REG_D = 3;
  localparam int REG_M1 = 4;
  localparam int REG_M2 = 5;
  localparam int REG_X = 6;
  localparam int REG_Y = 7;
  localparam int PAIR_M = 4;
  localparam int PAIR_XY = 6;
endpackage

// File: rtl/relay_settle_timer.sv
// relay_settle_timer: loadable down-counter with zero flag emulating relay settle time
module relay_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? CW'(SETTLE - 1) : (dec && !zero) ? cnt - CW'(1) : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/relay_register_bank.sv
// relay_register_bank: handshaked register file with pair access, incrementer and settle-timed bus drive
module relay_register_bank
  import relay_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 8,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_reg,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [2*DATA_W-1:0]        addr_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_oe,
  output logic [2*DATA_W-1:0]        addr_out,
  output logic                       addr_oe,
  output logic                       done,
  output logic                       err,
  output logic                       inc_carry,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
  localparam int RW = $clog2(NUM_REGS);
  stateT state;
  opT opQ;
  logic [RW-1:0] regQ, hiIdx, loIdx;
  logic [DATA_W-1:0] dataQ;
  logic [2*DATA_W-1:0] addrQ, pairVal;
  logic [2*DATA_W:0] pairInc;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic accept, busy, commit, timerZero, pairOp, illegal;
  assign accept = cmd_valid && cmd_ready;
  assign cmd_ready = state == ST_IDLE;
  assign busy = state != ST_IDLE;
  assign commit = state == ST_COMMIT;
  assign pairOp = opQ inside {OP_LD16, OP_SEL16, OP_INC16};
  assign illegal = opQ == OP_ILL || int'(regQ) >= NUM_REGS || (pairOp && regQ[0]);
  assign hiIdx = regQ & ~RW'(1);
  assign loIdx = regQ | RW'(1);
  assign pairVal = {regs[hiIdx], regs[loIdx]};
  assign pairInc = {1'b0, pairVal} + (2*DATA_W+1)'(1);
  // Bus enables are decoded from state flops so an async reset drops them at once
  assign data_oe = busy && !illegal && opQ == OP_SEL8;
  assign addr_oe = busy && !illegal && opQ == OP_SEL16;
  assign data_out = data_oe ? regs[regQ] : '0;
  assign addr_out = addr_oe ? pairVal : '0;
  assign done = commit;
  assign err = commit && illegal;
  relay_settle_timer #(.SETTLE(SETTLE)) uTimer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .dec  (state == ST_SETTLE),
    .zero (timerZero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= accept ? ST_SETTLE
                : (state == ST_SETTLE && timerZero) ? ST_COMMIT
                : commit ? ST_IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opQ <= OP_NOP;
      regQ <= '0;
      dataQ <= '0;
      addrQ <= '0;
    end else if (accept) begin
      opQ <= opT'(cmd_op);
      regQ <= cmd_reg;
      dataQ <= data_in;
      addrQ <= addr_in;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      inc_carry <= 1'b0;
    end else if (commit && !illegal) begin
      case (opQ)
        OP_LD8: regs[regQ] <= dataQ;
        OP_LD16: begin
          regs[hiIdx] <= addrQ[2*DATA_W-1:DATA_W];
          regs[loIdx] <= addrQ[DATA_W-1:0];
        end
        OP_INC16: begin
          regs[hiIdx] <= pairInc[2*DATA_W-1:DATA_W];
          regs[loIdx] <= pairInc[DATA_W-1:0];
          inc_carry <= pairInc[2*DATA_W];
        end
        OP_CLR8: regs[regQ] <= '0;
        default: ;
      endcase
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end
endmodule

// File: tb/tb_relay_register_bank.sv
// tb_relay_register_bank: vector table, corner sequences and random commands against a behavioural model
module tb_relay_register_bank;
  localparam int SETTLE = 2;
  logic clk = 0, rst_n = 0, cmd_valid = 0;
  logic cmd_ready, data_oe, addr_oe, done, err, inc_carry;
  logic [2:0] cmd_op = 0, cmd_reg = 0;
  logic [7:0] data_in = 0, data_out;
  logic [15:0] addr_in = 0, addr_out;
  logic [63:0] regs_flat;
  int checks = 0, errors = 0;
  logic [7:0] m [8];
  logic mCarry;
  logic [15:0] lastBus;
  logic lastErr;

  relay_register_bank #(.DATA_W(8), .NUM_REGS(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .data_in(data_in), .addr_in(addr_in),
    .data_out(data_out), .data_oe(data_oe), .addr_out(addr_out), .addr_oe(addr_oe),
    .done(done), .err(err), .inc_carry(inc_carry), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] r;
    logic [7:0] d;
    logic [15:0] a;
    logic [63:0] expFlat;
    logic [15:0] expBus;
    logic expErr;
    logic expCarry;
  } vecT;
  vecT tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] modelFlat();
    logic [63:0] f = '0;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m[i];
    return f;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    mCarry = 1'b0;
  endtask

  task automatic checkIdle(input string nm);
    chk({nm, "_ready"}, 64'(cmd_ready), 64'd1);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'd0);
    chk({nm, "_doe"}, 64'(data_oe), 64'd0);
    chk({nm, "_aoe"}, 64'(addr_oe), 64'd0);
    chk({nm, "_dout"}, 64'(data_out), 64'd0);
    chk({nm, "_aout"}, 64'(addr_out), 64'd0);
    chk({nm, "_flat"}, regs_flat, modelFlat());
    chk({nm, "_carry"}, 64'(inc_carry), 64'(mCarry));
  endtask

  // Issues one command from idle and checks every cycle until it is back in idle
  task automatic runCmd(input logic [2:0] op, input logic [2:0] r, input logic [7:0] d, input logic [15:0] a);
    bit pair = op >= 3 && op <= 5;
    bit ill = op == 3'd7 || (pair && r[0]);
    int hi = int'(r) & 6;
    int lo = hi + 1;
    logic [15:0] pv = {m[hi], m[lo]};
    bit expDoe = !ill && op == 3'd2;
    bit expAoe = !ill && op == 3'd4;
    @(negedge clk);
    chk("issue_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_op = op; cmd_reg = r; data_in = d; addr_in = a;
    @(negedge clk);
    cmd_valid = 0; cmd_op = 3'($urandom); cmd_reg = 3'($urandom); data_in = ~d; addr_in = ~a;
    for (int k = 1; k <= SETTLE + 1; k++) begin
      chk("busy_ready", 64'(cmd_ready), 64'd0);
      chk("done_time", 64'(done), 64'(k == SETTLE + 1));
      chk("err_time", 64'(err), 64'(k == SETTLE + 1 && ill));
      chk("data_oe", 64'(data_oe), 64'(expDoe));
      chk("data_out", 64'(data_out), expDoe ? 64'(m[r]) : 64'd0);
      chk("addr_oe", 64'(addr_oe), 64'(expAoe));
      chk("addr_out", 64'(addr_out), expAoe ? 64'(pv) : 64'd0);
      chk("flat_hold", regs_flat, modelFlat());
      if (k == SETTLE + 1) begin
        lastBus = data_oe ? 16'(data_out) : addr_out;
        lastErr = err;
      end else @(negedge clk);
    end
    if (!ill) begin
      case (op)
        3'd1: m[r] = d;
        3'd3: begin m[hi] = a[15:8]; m[lo] = a[7:0]; end
        3'd5: begin
          mCarry = pv == 16'hFFFF;
          pv = pv + 16'd1;
          m[hi] = pv[15:8]; m[lo] = pv[7:0];
        end
        3'd6: m[r] = 8'h00;
        default: ;
      endcase
    end
    @(negedge clk);
    checkIdle("after");
  endtask

  initial begin
    int acc, doneCnt;
    logic [7:0] cap;
    tbl[0]  = '{3'd1, 3'd0, 8'h5A, 16'h0000, 64'h0000_0000_0000_005A, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{3'd3, 3'd6, 8'h00, 16'h12FF, 64'hFF12_0000_0000_005A, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{3'd4, 3'd6, 8'h00, 16'h0000, 64'hFF12_0000_0000_005A, 16'h12FF, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 3'd4, 8'h00, 16'hFFFF, 64'hFF12_FFFF_0000_005A, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{3'd5, 3'd4, 8'h00, 16'h0000, 64'hFF12_0000_0000_005A, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{3'd5, 3'd4, 8'h00, 16'h0000, 64'hFF12_0100_0000_005A, 16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{3'd3, 3'd5, 8'h00, 16'hABCD, 64'hFF12_0100_0000_005A, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{3'd7, 3'd0, 8'hEE, 16'h0000, 64'hFF12_0100_0000_005A, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{3'd2, 3'd7, 8'h00, 16'h0000, 64'hFF12_0100_0000_005A, 16'h00FF, 1'b0, 1'b0};
    tbl[9]  = '{3'd6, 3'd7, 8'h00, 16'h0000, 64'h0012_0100_0000_005A, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{3'd1, 3'd1, 8'h33, 16'h0000, 64'h0012_0100_0000_335A, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{3'd2, 3'd1, 8'h00, 16'h0000, 64'h0012_0100_0000_335A, 16'h0033, 1'b0, 1'b0};
    modelReset();
    repeat (2) @(negedge clk);
    checkIdle("in_reset");
    rst_n = 1;
    @(negedge clk);
    checkIdle("post_reset");

    for (int i = 0; i < 12; i++) begin
      runCmd(tbl[i].op, tbl[i].r, tbl[i].d, tbl[i].a);
      chk($sformatf("tbl%0d_flat", i), regs_flat, tbl[i].expFlat);
      chk($sformatf("tbl%0d_carry", i), 64'(inc_carry), 64'(tbl[i].expCarry));
      chk($sformatf("tbl%0d_err", i), 64'(lastErr), 64'(tbl[i].expErr));
      if (tbl[i].op == 3'd2 || tbl[i].op == 3'd4)
        chk($sformatf("tbl%0d_bus", i), 64'(lastBus), 64'(tbl[i].expBus));
    end

    // cmd_valid held high while data_in keeps changing
    acc = 0; doneCnt = 0; cap = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd1; cmd_reg = 3'd2;
    for (int i = 0; i < 4 * (SETTLE + 2) / 2; i++) begin
      data_in = 8'($urandom);
      if (cmd_ready) begin acc++; cap = data_in; end
      if (done) doneCnt++;
      @(negedge clk);
    end
    cmd_valid = 0;
    m[2] = cap;
    chk("held_accepts", 64'(acc), 64'd2);
    chk("held_dones", 64'(doneCnt), 64'd2);
    checkIdle("held");

    // async reset during SETTLE of SEL8 r=1
    @(negedge clk);
    cmd_valid = 1; cmd_op = 3'd2; cmd_reg = 3'd1;
    @(negedge clk);
    cmd_valid = 0;
    chk("rst_pre_oe", 64'(data_oe), 64'd1);
    chk("rst_pre_out", 64'(data_out), 64'h33);
    #1 rst_n = 0;
    #1;
    modelReset();
    chk("rst_oe_drop", 64'(data_oe), 64'd0);
    chk("rst_out_zero", 64'(data_out), 64'd0);
    chk("rst_flat", regs_flat, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    doneCnt = 0;
    for (int i = 0; i < SETTLE + 3; i++) begin
      if (done) doneCnt++;
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
    end
    chk("rst_no_done", 64'(doneCnt), 64'd0);
    checkIdle("rst_after");

    for (int i = 0; i < 60; i++)
      runCmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/relay_register_bank.md
# relay_register_bank

Parametrised successor to the fixed eight-register file of the relay computer. It holds NUM_REGS registers of DATA_W bits, addressable singly (8-bit data bus) or as even/odd pairs (16-bit address bus, e.g. M = M1:M2, XY = X:Y). It adds what the static register set lacks:
- a command handshake;
- relay-style settle timing for every operation;
- an in-place 16-bit pair incrementer with carry;
- explicit bus-drive enables.

It sits between the sequencer FSM and the shared data/address buses.

## Interface
Parameters:
- DATA_W, 8, register width; pair width is 2*DATA_W
- NUM_REGS, 8, register count (even, ≥2); reset index map is A=0,B=1,C=2,D=3,M1=4,M2=5,X=6,Y=7
- SETTLE, 2, relay settle cycles per operation (≥1)

Ports:
- clk  in  1  clock; all flops rise-edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted when valid&ready
- cmd_op  in  3  operation code (see Operation)
- cmd_reg  in  $clog2(NUM_REGS)  register index; pair ops use even index = high byte
- data_in  in  DATA_W  data bus value for LD8
- addr_in  in  2*DATA_W  address bus value for LD16
- data_out  out  DATA_W  value driven onto data bus
- data_oe  out  1  data bus drive enable
- addr_out  out  2*DATA_W  value driven onto address bus
- addr_oe  out  1  address bus drive enable
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for illegal command
- inc_carry  out  1  carry of last INC16
- regs_flat  out  NUM_REGS*DATA_W  live register contents, reg i at bits [i*DATA_W +: DATA_W]

## Operation
Opcodes:
- 0 NOP: no change.
- 1 LD8: reg[r] ← data_in.
- 2 SEL8: drive reg[r] on data_out, data_oe=1.
- 3 LD16: {reg[r],reg[r+1]} ← addr_in.
- 4 SEL16: drive {reg[r],reg[r+1]} on addr_out, addr_oe=1.
- 5 INC16: pair ← pair+1 modulo 2^(2*DATA_W); inc_carry ← 1 iff pair was all-ones, else 0.
- 6 CLR8: reg[r] ← 0.
- 7: illegal.

Legality and error handling:
- A pair op (3,4,5) with odd r, any op with r ≥ NUM_REGS, or opcode 7 is illegal.
- An illegal command runs the full timing, then pulses err with done. No register, flag or bus-enable change.

Command capture:
- cmd_op, cmd_reg, data_in and addr_in are captured at acceptance.
- Later changes on those inputs are ignored.

FSM states:
- IDLE: cmd_ready=1. On accept → SETTLE, counter loaded with SETTLE-1.
- SETTLE: counter decrements each cycle; at 0 → COMMIT.
- COMMIT: done=1 (err if illegal). Register/flag write takes effect at the closing edge. → IDLE.

Bus drive:
- SEL ops assert their oe from the first SETTLE cycle through COMMIT inclusive.
- Outside that window, data_oe and addr_oe are 0, and data_out and addr_out are 0.

Other rules:
- Only one op is in flight. Writes and SELs never overlap.
- regs_flat reflects register flops directly.

## Timing
- Accept at edge E0. SETTLE occupies cycles E0+1 … E0+SETTLE. COMMIT is cycle E0+SETTLE+1. New value is visible on regs_flat from E0+SETTLE+2.
- Throughput: one command per SETTLE+2 cycles. The next accept is possible in the first IDLE cycle after COMMIT.
- cmd_valid held while not ready: no effect, no queueing.
- Reset values: all registers 0, inc_carry 0, done 0, err 0, data_oe/addr_oe 0, data_out/addr_out 0, cmd_ready 1, state IDLE.
- Reset asserted mid-operation: immediate return to reset values. The pending write is discarded and the oe drops asynchronously.

## Structure
- Package relay_pkg holds:
  - the op enum (OP_NOP…OP_ILL);
  - register index constants REG_A…REG_Y;
  - pair constants PAIR_M=4, PAIR_XY=6;
  - the FSM state enum.
- Sub-module relay_settle_timer: loadable down-counter with a zero flag, parametrised by SETTLE. It is reused by the memory and ALU relay emulations.

## Test plan
- Reset, then LD8 r=0 with data_in=0x5A, SETTLE=2: done pulses at E0+3; regs_flat[7:0]=0x5A at E0+4. Other registers stay 0.
- LD16 r=6 with addr_in=0x12FF, then SEL16 r=6: addr_oe=1 for cycles E0+1…E0+3, addr_out=0x12FF. Both are 0 before and after.
- INC16 pair 4 holding 0xFFFF: pair becomes 0x0000, inc_carry=1. A second INC16 gives 0x0001, inc_carry=0.
- Illegal commands: LD16 r=5, and op 7. err+done pulse at E0+3, registers unchanged, no oe asserted.
- cmd_valid held high with data_in changing during the op: only one accept per SETTLE+2 cycles, and the captured value is the one written.
- rst_n low during SETTLE of SEL8 r=1 (reg=0x33): data_oe falls immediately, all registers 0, cmd_ready=1 after release, and no done pulse.
